// File: rtl/tnn_pkg.sv
// tnn_pkg: shared defaults, widths and the weight type for the temporal
// spiking-neural-network layer (tnn_layer / tnn_neuron).
package tnn_pkg;

  localparam int TNN_NUM_SPIKES = 4;
  localparam int TNN_NEURONS    = 2;
  localparam int TNN_TIME_PERIOD = 8;                    // window length, cycles
  localparam int TNN_TW         = $clog2(TNN_TIME_PERIOD) + 1; // also encodes "no spike"
  localparam int TNN_WMAX       = 7;
  localparam int TNN_WINIT      = 4;
  localparam int TNN_THRESHOLD  = 8;

  typedef logic [$clog2(TNN_WMAX+1)-1:0] weight_t;

endpackage

// File: rtl/tnn_neuron.sv
// tnn_neuron: one neuron of the layer. Holds its weights, membrane potential,
// fired flag and fire time; applies winner-only STDP when stdp_en_i is set.
// Ports:
//   clk, rst        clock, async active-high reset
//   time_val_i      current time in window (0 = window start)
//   spike_times_i   per-input spike time; >= TIME_PERIOD means no spike
//   stdp_en_i       this neuron is the final winner on the last window cycle
//   fire_o          combinational: neuron crosses threshold this cycle
module tnn_neuron
  import tnn_pkg::*;
#(
  parameter int NUM_SPIKES  = TNN_NUM_SPIKES,
  parameter int TIME_PERIOD = TNN_TIME_PERIOD,
  parameter int WMAX        = TNN_WMAX,
  parameter int WINIT       = TNN_WINIT,
  parameter int THRESHOLD   = TNN_THRESHOLD,
  localparam int TW         = $clog2(TIME_PERIOD) + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [TW-1:0]                  time_val_i,
  input  logic [NUM_SPIKES-1:0][TW-1:0]  spike_times_i,
  input  logic                           stdp_en_i,
  output logic                           fire_o
);

  localparam int WW   = $clog2(WMAX + 1);
  // potential must hold a full window of max-weight spikes and the threshold
  localparam int PMAX = (NUM_SPIKES * WMAX > THRESHOLD) ? NUM_SPIKES * WMAX : THRESHOLD;
  localparam int PW   = $clog2(PMAX + 1);

  localparam logic [WW-1:0] W_MAX    = WW'(WMAX);
  localparam logic [WW-1:0] W_INIT   = WW'(WINIT);
  localparam logic [PW-1:0] P_MAX    = PW'(PMAX);
  localparam logic [PW-1:0] THR      = PW'(THRESHOLD);
  localparam logic [TW-1:0] NO_SPIKE = TW'(TIME_PERIOD);

  logic [NUM_SPIKES-1:0][WW-1:0] weight_q, weight_d;
  logic [PW-1:0]                 pot_q, pot_d;
  logic                          fired_q, fired_d;
  logic [TW-1:0]                 ftime_q, ftime_d;
  logic [PW:0]                   sum;
  logic                          win_start, fired_eff;

  always_comb begin
    win_start = (time_val_i == '0);
    // window start discards the old potential and fire state before this cycle's test
    sum       = win_start ? '0 : {1'b0, pot_q};
    for (int i = 0; i < NUM_SPIKES; i++)
      if (spike_times_i[i] == time_val_i) sum = sum + (PW+1)'(weight_q[i]);
    // only reachable if spike_times changes mid-window and re-hits time_val
    pot_d     = (sum > {1'b0, P_MAX}) ? P_MAX : sum[PW-1:0];
    fired_eff = fired_q & ~win_start;
    fire_o    = ~fired_eff && (pot_d >= THR);
    fired_d   = fired_eff | fire_o;
    ftime_d   = fire_o ? time_val_i : ftime_q;

    // ftime_d includes a fire in this same (last) cycle
    weight_d = weight_q;
    if (stdp_en_i) begin
      for (int i = 0; i < NUM_SPIKES; i++) begin
        if (spike_times_i[i] < NO_SPIKE && spike_times_i[i] <= ftime_d) begin
          if (weight_q[i] < W_MAX) weight_d[i] = weight_q[i] + 1'b1;
        end else begin
          if (weight_q[i] != '0) weight_d[i] = weight_q[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      weight_q <= {NUM_SPIKES{W_INIT}};
      pot_q    <= '0;
      fired_q  <= 1'b0;
      ftime_q  <= NO_SPIKE;
    end else begin
      weight_q <= weight_d;
      pot_q    <= pot_d;
      fired_q  <= fired_d;
      ftime_q  <= ftime_d;
    end
  end

endmodule

// File: rtl/tnn_layer.sv
// tnn_layer: single-column temporal SNN layer. NEURONS tnn_neuron instances
// share the input spike lines; a winner-take-all arbiter latches the first
// (lowest-index) firing neuron of each window and its fire time.
// Ports:
//   clk, rst           clock, async active-high reset
//   training           1 = winner-only STDP at window end, 0 = weights frozen
//   time_val           external window time, 0..TIME_PERIOD-1, wraps
//   spike_times        packed, entry i = spike time of input i
//   output_spike_time  winner fire time, TIME_PERIOD when no winner
//   winning_neuron     winner index, NEURONS when no winner
module tnn_layer
  import tnn_pkg::*;
#(
  parameter int NUM_SPIKES  = TNN_NUM_SPIKES,
  parameter int NEURONS     = TNN_NEURONS,
  parameter int TIME_PERIOD = TNN_TIME_PERIOD,
  parameter int WMAX        = TNN_WMAX,
  parameter int WINIT       = TNN_WINIT,
  parameter int THRESHOLD   = TNN_THRESHOLD,
  localparam int TW         = $clog2(TIME_PERIOD) + 1,
  localparam int NW         = $clog2(NEURONS) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          training,
  input  logic [TW-1:0]                 time_val,
  input  logic [NUM_SPIKES-1:0][TW-1:0] spike_times,
  output logic [TW-1:0]                 output_spike_time,
  output logic [NW-1:0]                 winning_neuron
);

  localparam logic [NW-1:0] NO_WIN  = NW'(NEURONS);
  localparam logic [TW-1:0] NO_TIME = TW'(TIME_PERIOD);
  localparam logic [TW-1:0] LAST_T  = TW'(TIME_PERIOD - 1);

  logic [NEURONS-1:0] fire, stdp_en;
  logic [NW-1:0]      win_q, win_d;
  logic [TW-1:0]      wtime_q, wtime_d;

  for (genvar n = 0; n < NEURONS; n++) begin : g_nrn
    tnn_neuron #(
      .NUM_SPIKES (NUM_SPIKES),
      .TIME_PERIOD(TIME_PERIOD),
      .WMAX       (WMAX),
      .WINIT      (WINIT),
      .THRESHOLD  (THRESHOLD)
    ) u_nrn (
      .clk          (clk),
      .rst          (rst),
      .time_val_i   (time_val),
      .spike_times_i(spike_times),
      .stdp_en_i    (stdp_en[n]),
      .fire_o       (fire[n])
    );
  end

  always_comb begin
    win_d   = win_q;
    wtime_d = wtime_q;
    // clear first so a fire at time 0 still wins the new window
    if (time_val == '0) begin
      win_d   = NO_WIN;
      wtime_d = NO_TIME;
    end
    if (win_d == NO_WIN && |fire) begin
      for (int n = NEURONS - 1; n >= 0; n--)
        if (fire[n]) win_d = NW'(n);
      wtime_d = time_val;
    end
    // win_d == NO_WIN never matches a neuron index, so no winner = no STDP
    for (int n = 0; n < NEURONS; n++)
      stdp_en[n] = training && (time_val == LAST_T) && (win_d == NW'(n));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q   <= NO_WIN;
      wtime_q <= NO_TIME;
    end else begin
      win_q   <= win_d;
      wtime_q <= wtime_d;
    end
  end

  assign winning_neuron    = win_q;
  assign output_spike_time = wtime_q;

endmodule

// File: tb/tb_tnn_layer.sv
module tb_tnn_layer;
  localparam int NS = 4, NN = 2, TP = 8, TW = 4, NW = 2;

  logic                  clk = 1'b0;
  logic                  rst, training;
  logic [TW-1:0]         time_val;
  logic [NS-1:0][TW-1:0] spike_times;
  logic [TW-1:0]         output_spike_time;
  logic [NW-1:0]         winning_neuron;
  logic [NS-1:0][2:0]    w0_act, w1_act;

  tnn_layer dut (
    .clk(clk), .rst(rst), .training(training), .time_val(time_val),
    .spike_times(spike_times), .output_spike_time(output_spike_time),
    .winning_neuron(winning_neuron)
  );

  assign w0_act = dut.g_nrn[0].u_nrn.weight_q;
  assign w1_act = dut.g_nrn[1].u_nrn.weight_q;

  always #5 clk = ~clk;

  typedef struct {
    logic                  tr;
    logic [NS-1:0][TW-1:0] sp;
    int                    win;  // expected winner after the window
    int                    wt;   // its fire time (TP = none)
    logic [NS-1:0][2:0]    w0, w1;
  } vec_t;

  vec_t tbl[$];
  int   tests = 0, fails = 0;

  function automatic logic [NS-1:0][TW-1:0] sp4(int a, int b, int c, int d);
    logic [NS-1:0][TW-1:0] r;
    r[0] = TW'(a); r[1] = TW'(b); r[2] = TW'(c); r[3] = TW'(d);
    return r;
  endfunction

  function automatic logic [NS-1:0][2:0] w4(int a, int b, int c, int d);
    logic [NS-1:0][2:0] r;
    r[0] = 3'(a); r[1] = 3'(b); r[2] = 3'(c); r[3] = 3'(d);
    return r;
  endfunction

  function automatic vec_t mk(logic tr, logic [NS-1:0][TW-1:0] sp, int win, int wt,
                              logic [NS-1:0][2:0] w0, logic [NS-1:0][2:0] w1);
    vec_t v;
    v.tr = tr; v.sp = sp; v.win = win; v.wt = wt; v.w0 = w0; v.w1 = w1;
    return v;
  endfunction

  task automatic chk_out(string nm, int win, int tim);
    tests++;
    if (int'(winning_neuron) != win || int'(output_spike_time) != tim) begin
      fails++;
      $display("FAIL %s: winner=%0d time=%0d, expected winner=%0d time=%0d",
               nm, winning_neuron, output_spike_time, win, tim);
    end
  endtask

  task automatic chk_w(string nm, logic [NS-1:0][2:0] e0, logic [NS-1:0][2:0] e1);
    tests++;
    if (w0_act !== e0 || w1_act !== e1) begin
      fails++;
      $display("FAIL %s: w0=%h w1=%h, expected w0=%h w1=%h", nm, w0_act, w1_act, e0, e1);
    end
  endtask

  // drive one full window, checking outputs after every edge and weights at the end
  task automatic run_window(vec_t v, int idx);
    for (int t = 0; t < TP; t++) begin
      training    = v.tr;
      spike_times = v.sp;
      time_val    = TW'(t);
      @(posedge clk); #1;
      if (t >= v.wt) chk_out($sformatf("win%0d_t%0d", idx, t), v.win, v.wt);
      else           chk_out($sformatf("win%0d_t%0d", idx, t), NN, TP);
    end
    chk_w($sformatf("win%0d_weights", idx), v.w0, v.w1);
  endtask

  initial begin
    logic [NS-1:0][2:0] w4s;
    w4s = w4(4, 4, 4, 4);

    rst = 1'b1; training = 1'b0; time_val = '0; spike_times = sp4(8, 8, 8, 8);
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset_out", NN, TP);
    chk_w("reset_w", w4s, w4s);
    rst = 1'b0;

    tbl.push_back(mk(1'b0, sp4(8, 8, 8, 8), NN, TP, w4s, w4s));             // no input
    tbl.push_back(mk(1'b0, sp4(0, 1, 8, 8), 0, 1, w4s, w4s));               // inference
    tbl.push_back(mk(1'b1, sp4(0, 1, 8, 8), 0, 1, w4(5, 5, 3, 3), w4s));    // one STDP step
    tbl.push_back(mk(1'b0, sp4(0, 1, 8, 8), 0, 1, w4(5, 5, 3, 3), w4s));    // n0 reaches 10 at t1
    tbl.push_back(mk(1'b0, sp4(8, 8, 0, 1), 1, 1, w4(5, 5, 3, 3), w4s));    // n0 only 6
    // saturation at WMAX: all inputs at t0, n0 wins at time 0
    tbl.push_back(mk(1'b1, sp4(0, 0, 0, 0), 0, 0, w4(6, 6, 4, 4), w4s));
    tbl.push_back(mk(1'b1, sp4(0, 0, 0, 0), 0, 0, w4(7, 7, 5, 5), w4s));
    tbl.push_back(mk(1'b1, sp4(0, 0, 0, 0), 0, 0, w4(7, 7, 6, 6), w4s));
    tbl.push_back(mk(1'b1, sp4(0, 0, 0, 0), 0, 0, w4(7, 7, 7, 7), w4s));
    tbl.push_back(mk(1'b1, sp4(0, 0, 0, 0), 0, 0, w4(7, 7, 7, 7), w4s));
    // floor at 0: inputs 2,3 silent, decrement each window
    for (int k = 1; k <= 8; k++) begin
      int lo;
      lo = (7 - k < 0) ? 0 : 7 - k;
      tbl.push_back(mk(1'b1, sp4(0, 0, 8, 8), 0, 0, w4(7, 7, lo, lo), w4s));
    end
    tbl.push_back(mk(1'b0, sp4(8, 8, 0, 1), 1, 1, w4(7, 7, 0, 0), w4s));

    foreach (tbl[i]) run_window(tbl[i], i);

    // reset mid-window at t=4
    training = 1'b0; spike_times = sp4(0, 1, 8, 8);
    for (int t = 0; t < 4; t++) begin
      time_val = TW'(t);
      @(posedge clk); #1;
      if (t >= 1) chk_out($sformatf("pre_rst_t%0d", t), 0, 1);
      else        chk_out($sformatf("pre_rst_t%0d", t), NN, TP);
    end
    time_val = TW'(4);
    #2 rst = 1'b1;
    #1;
    chk_out("rst_async_out", NN, TP);
    chk_w("rst_async_w", w4s, w4s);
    @(posedge clk); #1;
    chk_out("rst_held_out", NN, TP);
    rst = 1'b0;
    run_window(mk(1'b0, sp4(0, 1, 8, 8), 0, 1, w4s, w4s), 99);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tnn_layer.md
Name: tnn_layer

Overview:
- Single-column temporal spiking-neural-network layer: NEURONS neurons, each fully connected to NUM_SPIKES input lines carrying one spike time per line per time window.
- Each neuron accumulates weighted input spikes and fires on threshold crossing; winner-take-all picks the earliest-firing neuron.
- While training is high, winner-only STDP updates weights at the end of each window.
- Driven by an external free-running time counter; sits between the input spike encoder and the result classifier.

Parameters:
- NUM_SPIKES, 4, number of input spike lines.
- NEURONS, 2, neurons in the layer.
- TIME_PERIOD, 8, window length in cycles; time values 0..TIME_PERIOD-1; any value >= TIME_PERIOD means "no spike".
- WMAX, 7, saturating weight maximum (weights are unsigned, 0..WMAX).
- WINIT, 4, reset value of every weight.
- THRESHOLD, 8, firing threshold (fire when potential >= THRESHOLD).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- training  in  1  1 = apply STDP at window end; 0 = inference only, weights frozen.
- time_val  in  $clog2(TIME_PERIOD)+1  current time in window, supplied externally, counts 0..TIME_PERIOD-1 and wraps.
- spike_times  in  NUM_SPIKES x ($clog2(TIME_PERIOD)+1)  packed array, entry i = spike time of input i.
- output_spike_time  out  $clog2(TIME_PERIOD)+1  fire time of current winner; TIME_PERIOD when no winner.
- winning_neuron  out  $clog2(NEURONS)+1  index of current winner; NEURONS when no winner.

Behaviour:
- Widths: TW = $clog2(TIME_PERIOD)+1, NW = $clog2(NEURONS)+1. Potential width must hold NUM_SPIKES*WMAX without overflow.
- State: weight[n][i], potential[n], fired[n], fire_time[n], winner register, winner time register.
- Per clock, contrib[n] = sum of weight[n][i] over inputs with spike_times[i] == time_val (step response, no leak).
- If time_val == 0: potential[n] <= contrib[n] and fired[n] is cleared, with the new fire test applied. Otherwise potential[n] <= potential[n] + contrib[n].
- Neuron n fires at the edge where new potential >= THRESHOLD and fired[n] == 0. It then sets fired[n] and records fire_time[n] = time_val. Only one fire per window.
- Winner-take-all:
  - At time_val == 0, the winner register clears to "no winner" before evaluating that cycle's fires.
  - The first cycle with any fire latches the lowest-index firing neuron and its time_val.
  - Later fires in the same window never change the winner.
- Outputs are registered, driven directly from the winner registers, and visible one edge after the crossing cycle. They are held until the next window start.
- STDP runs on the edge where time_val == TIME_PERIOD-1, only when training == 1 and a winner exists. It uses that cycle's final winner (including a fire in that same cycle).
  - For the winner w and each input i: if spike_times[i] < TIME_PERIOD and spike_times[i] <= fire_time[w], then weight[w][i] += 1, saturating at WMAX.
  - Otherwise weight[w][i] -= 1, saturating at 0.
  - Non-winners are unchanged.
- training == 0: weights never change.
- spike_times is sampled combinationally every cycle. A change mid-window affects only later cycles.
- Reset (any time, including mid-window):
  - all weights = WINIT;
  - potentials = 0, fired = 0;
  - winning_neuron = NEURONS, output_spike_time = TIME_PERIOD.

Decomposition:
- Shared package tnn_pkg holds defaults and widths: TIME_PERIOD, TW, WMAX, WINIT, THRESHOLD, and a weight_t typedef (clog2(WMAX+1) bits).
- One sub-module, tnn_neuron, holds the weights, potential, fire logic and STDP for one neuron. It is instantiated NEURONS times via generate.
- The winner-take-all arbiter and output registers live in tnn_layer.

Test Plan:
- Reset, then spike_times = {8,8,8,8} for a full window -> winning_neuron = 2, output_spike_time = 8 throughout; weights unchanged.
- training=0, spike_times = {0,1,8,8} (inputs 0..3), all weights 4 -> potentials 4 at t=0, 8 at t=1; both neurons fire at t=1; winning_neuron = 0, output_spike_time = 1 from the edge after t=1 until the next window; weights stay 4.
- training=1, same input for one window -> neuron 0 weights become {5,5,3,3}, neuron 1 stays {4,4,4,4}. Next window with the same input: neuron 0 reaches 10 at t=1 and wins, time 1.
- After the previous step, training=0, spike_times = {8,8,0,1} -> neuron 0 reaches 6 (no fire); neuron 1 reaches 8 at t=1; winning_neuron = 1, output_spike_time = 1.
- Saturation: train neuron 0 on {0,0,0,0} for 5 windows -> all its weights = 7, no wrap. Train on a pattern where neuron 0's non-spiking inputs decrement repeatedly -> those weights floor at 0.
- Assert rst at t=4 mid-window -> outputs return to 2/8 immediately; all weights read back 4; the next window behaves as after power-up.
